// File: rtl/hilo_pkg.sv
// Shared constants for the HI/LO multiply sequencer: op codes, FSM state codes, step count.
package hilo_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_MADD  = 3'd3;
  localparam logic [2:0] OP_MSUB  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam int MUL_STEPS = 32;

endpackage

// File: rtl/seq_mult_core.sv
// Unsigned radix-2 shift-add multiplier datapath: one partial-product step per step pulse.
module seq_mult_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     sum;

  always_comb begin
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    // The add carry becomes the new top bit once the product shifts right.
    sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    if (load) begin
      mcand_d = mcand_in;
      prod_d  = {{WIDTH{1'b0}}, mplier_in};
      cnt_d   = '0;
    end else if (step) begin
      if (prod_q[0]) begin
        prod_d = {sum, prod_q[WIDTH-1:1]};
      end else begin
        prod_d = {1'b0, prod_q[2*WIDTH-1:1]};
      end
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  assign product = prod_q;
  assign last    = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/hilo_mul_seq.sv
// MIPS HI/LO owner: sequences MULT/MULTU/MADD/MSUB over 34 edges and handles MTHI/MTLO in one.
module hilo_mul_seq
  import hilo_pkg::*;
#(
  parameter int WIDTH = MUL_STEPS,
  parameter int CNT_W = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiLoRead,
  input  logic             Abort,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  logic [1:0]         state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               core_load;
  logic               core_step;
  logic [WIDTH-1:0]   mcand_in;
  logic [WIDTH-1:0]   mplier_in;
  logic [2*WIDTH-1:0] product;
  logic               core_last;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] p_signed;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] result;

  // Two's-complement negation of 0x80000000 yields 0x80000000, its correct unsigned magnitude.
  assign a_mag    = A[WIDTH-1] ? (WIDTH'(0) - A) : A;
  assign b_mag    = B[WIDTH-1] ? (WIDTH'(0) - B) : B;
  assign p_signed = neg_q ? ((2*WIDTH)'(0) - product) : product;
  assign acc      = {hi_q, lo_q};

  always_comb begin
    case (op_q)
      OP_MADD: result = acc + p_signed;
      OP_MSUB: result = acc - p_signed;
      default: result = p_signed;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_d     = neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    core_load = 1'b0;
    core_step = 1'b0;
    mcand_in  = A;
    mplier_in = B;
    case (state_q)
      ST_IDLE: begin
        if (Start && !Abort) begin
          case (Op)
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            OP_MULT, OP_MADD, OP_MSUB: begin
              op_d      = Op;
              neg_d     = A[WIDTH-1] ^ B[WIDTH-1];
              mcand_in  = a_mag;
              mplier_in = b_mag;
              core_load = 1'b1;
              state_d   = ST_CALC;
            end
            OP_MULTU: begin
              op_d      = Op;
              neg_d     = 1'b0;
              core_load = 1'b1;
              state_d   = ST_CALC;
            end
            default: ;
          endcase
        end
      end
      ST_CALC: begin
        if (Abort) begin
          state_d = ST_IDLE;
        end else begin
          core_step = 1'b1;
          if (core_last) begin
            state_d = ST_FIX;
          end
        end
      end
      ST_FIX: begin
        // A flush arriving with the commit wins; HI/LO stay untouched.
        if (!Abort) begin
          {hi_d, lo_d} = result;
          done_d       = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  seq_mult_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk       (Clk),
    .rst_n     (Reset),
    .load      (core_load),
    .step      (core_step),
    .mcand_in  (mcand_in),
    .mplier_in (mplier_in),
    .product   (product),
    .last      (core_last)
  );

  assign Busy  = (state_q != ST_IDLE);
  assign Stall = Busy & (Start | HiLoRead);
  assign Done  = done_q;
  assign Hi    = hi_q;
  assign Lo    = lo_q;

endmodule

// File: doc/hilo_mul_seq.md
Name: hilo_mul_seq

Overview:
- Multi-cycle sequencer for the MIPS HI/LO multiply group: MULT, MULTU, MADD, MSUB, MTHI, MTLO.
- Owns the architectural HI/LO registers and feeds them to the combinational ALU as Hi_in/Lo_in.
- Runs an iterative 32-step shift-add multiply, then stalls the pipeline through a Busy/Stall handshake until the product is committed.
- Sits in the EX stage beside the ALU. Decode supplies the operation code and register operands.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH and the product is 2*WIDTH.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == WIDTH.

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  request; Op/A/B sampled when Start=1 and state is IDLE
- Op  in  3  operation code (see package)
- A  in  WIDTH  rs operand
- B  in  WIDTH  rt operand
- HiLoRead  in  1  decode has MFHI/MFLO in EX
- Abort  in  1  pipeline flush; cancels the in-flight operation
- Busy  out  1  state != IDLE
- Stall  out  1  Busy & (Start | HiLoRead)
- Done  out  1  one-cycle pulse when HI/LO commit
- Hi  out  WIDTH  architectural HI register
- Lo  out  WIDTH  architectural LO register

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset value: state=IDLE, Hi=0, Lo=0, Done=0, Busy=0, counter=0, internal accumulators=0.
- Reset asserted mid-operation: the operation is discarded and Hi/Lo return to 0.
- States: IDLE, CALC, FIX.
- IDLE:
  - Start with Op=MTHI: Hi<=A at that edge; state stays IDLE; no Busy.
  - Start with Op=MTLO: Lo<=A at that edge; state stays IDLE; no Busy.
  - Start with Op=NOP or an undefined code: ignored.
  - Start with MULT/MULTU/MADD/MSUB at edge 0: latch Op.
  - Signed ops (MULT/MADD/MSUB): latch |A| and |B|, and neg = A[31]^B[31].
  - MULTU: latch A and B unchanged, neg=0.
  - Clear the product register and counter; go to CALC.
- CALC, one step per edge:
  - If multiplier bit 0 is set, add the multiplicand into the upper product half.
  - Shift the product right by 1; counter+1.
  - After 32 steps (edges 1..32), go to FIX.
- FIX, edge 33:
  - p = neg ? -product : product (64-bit two's complement).
  - MULT/MULTU: {Hi,Lo}<=p.
  - MADD: {Hi,Lo}<={Hi,Lo}+p.
  - MSUB: {Hi,Lo}<={Hi,Lo}-p.
  - 64-bit wrap-around; no overflow flag.
  - Done<=1 for exactly the cycle after edge 33; state<=IDLE.
- Latency:
  - New Hi/Lo are visible after edge 33, i.e. 34 edges after acceptance.
  - Busy is high for the 33 cycles following edges 0..32.
- Boundary cases:
  - Start while Busy is not accepted. Stall=1; the requester holds Start/Op/A/B until Busy falls, and the request is accepted on the first IDLE edge.
  - HiLoRead while Busy: Stall=1. Hi/Lo keep their pre-operation values until the FIX commit.
  - HiLoRead in the Done cycle: no stall; the new value is already visible.
  - Abort in CALC or FIX: next state IDLE, Hi/Lo unchanged, no Done. Abort outranks the FIX commit at the same edge.
  - Abort in IDLE has no effect. Abort together with Start in IDLE: the Start is dropped.
  - Operand -2^31 (0x80000000): its magnitude is 0x80000000 as unsigned, which must be handled correctly.
  - A=0 or B=0: still takes the full 34 edges (fixed latency, no early-out).

Decomposition:
- Package hilo_pkg:
  - Op codes: OP_NOP=3'd0, OP_MULT=3'd1, OP_MULTU=3'd2, OP_MADD=3'd3, OP_MSUB=3'd4, OP_MTHI=3'd5, OP_MTLO=3'd6.
  - State encoding: IDLE=2'd0, CALC=2'd1, FIX=2'd2.
  - Constant MUL_STEPS=32.
- One sub-module, seq_mult_core: the unsigned shift-add datapath (multiplicand, product register, counter). It has inputs load/step and outputs product/last.
- Sign handling, accumulation, HI/LO and the FSM stay in hilo_mul_seq.

Test Plan:
- Reset low mid-CALC -> Hi=0, Lo=0, Busy=0 immediately, without waiting for a clock edge. Release, then MULT 5×6 -> Lo=0x1E, Hi=0.
- MULT A=0xFFFFFFFD (-3), B=7 -> Done 34 edges after acceptance; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Busy high for exactly 33 cycles.
- MULTU A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
- MULT A=B=0x80000000 -> Hi=0x40000000, Lo=0.
- MTLO A=10 and MTHI A=0 in IDLE (each updates at the next edge), then MADD 2×3 -> Lo=16; then MSUB 4×5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFC.
- Start a second MULT and assert HiLoRead 5 cycles into CALC -> Stall=1 and the old Hi/Lo are held. The second MULT is accepted the cycle after Done. Separately, Abort at CALC step 10 -> IDLE, Hi/Lo unchanged, no Done.
